// File: rtl/binary_to_bcd_serial_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared types and constants for the serial binary-to-BCD converter.
//   - state_e        : converter FSM states (IDLE, CONVERT)
//   - BCD_DIGIT_W    : bits per packed BCD digit
//   - ADD3_THRESHOLD : digit value at or above which the pre-shift
//                      correction is applied
//   - ADD3_VALUE     : correction added to such a digit
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_e;

  localparam int BCD_DIGIT_W    = 4;
  localparam int ADD3_THRESHOLD = 5;
  localparam int ADD3_VALUE     = 3;

endpackage : bcd_pkg

// File: rtl/binary_to_bcd_serial_if.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_serial_if
//   Start/done handshake bundle between the value source and the converter.
//   Parameters N (binary width) and DIGITS (BCD digit count) must match the
//   converter instance the bundle is connected to.
//   Signals:
//     start    : request conversion of bin (source -> converter)
//     bin      : unsigned binary value, N bits (source -> converter)
//     busy     : conversion in progress (converter -> source)
//     done     : one-cycle pulse, bcd/overflow just updated
//     bcd      : packed BCD result, digit 0 in bits [3:0]
//     overflow : last value did not fit in DIGITS decimal digits
//   Modports:
//     master : the value source / sink of the result
//     slave  : the converter
// ---------------------------------------------------------------------------
interface binary_to_bcd_serial_if #(
  parameter int N      = 9,
  parameter int DIGITS = 3
);

  logic                  start;
  logic [N-1:0]          bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output overflow
  );

endinterface : binary_to_bcd_serial_if

// File: rtl/binary_to_bcd_serial_digit_adjust.sv
// ---------------------------------------------------------------------------
// bcd_digit_adjust
//   Combinational double-dabble correction for one BCD digit: a digit of
//   ADD3_THRESHOLD or more gets ADD3_VALUE added so that the following left
//   shift carries correctly into the next decimal digit. The sum stays
//   within 4 bits for every digit value the algorithm can produce (0..9),
//   so no carry leaves the digit.
//   Ports:
//     digit_in  : current 4-bit scratch digit
//     digit_out : corrected digit
// ---------------------------------------------------------------------------
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  localparam logic [BCD_DIGIT_W-1:0] THRESH = BCD_DIGIT_W'(ADD3_THRESHOLD);
  localparam logic [BCD_DIGIT_W-1:0] ADDEND = BCD_DIGIT_W'(ADD3_VALUE);

  assign digit_out = (digit_in >= THRESH) ? (digit_in + ADDEND) : digit_in;

endmodule : bcd_digit_adjust

// File: rtl/binary_to_bcd_serial.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_serial
//   Iterative shift-and-add-3 (double-dabble) converter. A value accepted
//   on a start edge is converted over N clock cycles; the packed BCD result
//   and an overflow flag are then held stable until the next conversion
//   completes.
//   Parameters:
//     N      : width of the binary input (N >= 1)
//     DIGITS : number of BCD digits produced
//   Ports:
//     clock  : system clock, all state changes on the rising edge
//     resetn : asynchronous active-low reset
//     bus    : handshake bundle (slave side), see binary_to_bcd_serial_if
//   Timing:
//     start accepted at edge 0 -> busy from edge 0 to edge N, one shift per
//     edge 1..N, done high for the cycle after edge N. A start seen during
//     the done cycle is accepted, so back-to-back conversions are N+1
//     cycles apart. Starts while busy are ignored.
// ---------------------------------------------------------------------------
module binary_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int N      = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  binary_to_bcd_serial_if.slave bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  // FSM
  state_e state_reg;
  state_e state_next;

  // Scratch datapath: {digits, bin} form one long shift register
  logic [N-1:0]     bin_reg;
  logic [N-1:0]     bin_next;
  logic [N-1:0]     bin_shift;
  logic [BCD_W-1:0] digits_reg;
  logic [BCD_W-1:0] digits_next;
  logic [BCD_W-1:0] digits_adj;
  logic [BCD_W-1:0] digits_shift;
  logic             ovf_reg;
  logic             ovf_next;
  logic             ovf_shift;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Registered outputs
  logic             busy_reg;
  logic             busy_next;
  logic             done_reg;
  logic             done_next;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_next;
  logic             overflow_reg;
  logic             overflow_next;

  // Decoded conditions
  logic             accept;
  logic             last_shift;

  assign accept     = (state_reg == IDLE) && bus.start;
  assign last_shift = (state_reg == CONVERT) && (cnt_reg == CNT_LAST);

  // -------------------------------------------------------------------------
  // Per-digit add-3 correction, applied before every shift
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_in  (digits_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_out (digits_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // One left shift of {digits_adj, bin_reg}: the binary MSB enters digit 0
  // and whatever falls off the top digit is a decimal overflow.
  assign digits_shift = {digits_adj[BCD_W-2:0], bin_reg[N-1]};
  assign bin_shift    = bin_reg << 1;
  assign ovf_shift    = ovf_reg | digits_adj[BCD_W-1];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic. Outputs are computed one cycle ahead and registered
  // so that busy/done/bcd/overflow all come straight from flops.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_next     = (state_next == CONVERT);
    done_next     = last_shift;
    bcd_next      = bcd_reg;
    overflow_next = overflow_reg;
    if (last_shift) begin
      bcd_next      = digits_shift;
      overflow_next = ovf_shift;
    end
  end

  // -------------------------------------------------------------------------
  // Scratch datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    bin_next    = bin_reg;
    digits_next = digits_reg;
    ovf_next    = ovf_reg;
    cnt_next    = cnt_reg;
    if (accept) begin
      bin_next    = bus.bin;
      digits_next = '0;
      ovf_next    = 1'b0;
      cnt_next    = CNT_LOAD;
    end else if (state_reg == CONVERT) begin
      bin_next    = bin_shift;
      digits_next = digits_shift;
      ovf_next    = ovf_shift;
      cnt_next    = cnt_reg - CNT_LAST;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bin_reg      <= '0;
      digits_reg   <= '0;
      ovf_reg      <= 1'b0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bcd_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      bin_reg      <= bin_next;
      digits_reg   <= digits_next;
      ovf_reg      <= ovf_next;
      cnt_reg      <= cnt_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      bcd_reg      <= bcd_next;
      overflow_reg <= overflow_next;
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.bcd      = bcd_reg;
  assign bus.overflow = overflow_reg;

endmodule : binary_to_bcd_serial

// File: tb/tb_binary_to_bcd_serial.sv
// ---------------------------------------------------------------------------
// tb_binary_to_bcd_serial
//   Directed bench for the serial binary-to-BCD converter. Two instances:
//   N=9/DIGITS=3 (main) and N=8/DIGITS=2 (overflow cases).
// ---------------------------------------------------------------------------
module tb_binary_to_bcd_serial;

  logic clock;
  logic resetn;

  int checks;
  int errors;

  binary_to_bcd_serial_if #(.N(9), .DIGITS(3)) bus9 ();
  binary_to_bcd_serial_if #(.N(8), .DIGITS(2)) bus8 ();

  binary_to_bcd_serial #(.N(9), .DIGITS(3)) u_dut9 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus9.slave)
  );

  binary_to_bcd_serial #(.N(8), .DIGITS(2)) u_dut8 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus8.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: pack v into 3 BCD digits by repeated division.
  function automatic int unsigned ref_bcd3(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v;
    for (int i = 0; i < 3; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // One full conversion on the selected instance. Returns the number of
  // cycles from the accepting edge to the first cycle with done high.
  task automatic run_conv(input bit use8, input int unsigned v,
                          output int lat, output int unsigned bcd_out,
                          output bit ovf_out);
    @(negedge clock);
    if (use8) begin
      bus8.start = 1'b1;
      bus8.bin   = 8'(v);
    end else begin
      bus9.start = 1'b1;
      bus9.bin   = 9'(v);
    end
    @(negedge clock);
    bus8.start = 1'b0;
    bus9.start = 1'b0;
    // Scramble the input after the accepting edge; it must not matter.
    bus8.bin = ~8'(v);
    bus9.bin = ~9'(v);
    check_eq("busy_after_start", use8 ? bus8.busy : bus9.busy, 1);
    lat = 0;
    while (!(use8 ? bus8.done : bus9.done) && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    bcd_out = use8 ? 32'(bus8.bcd) : 32'(bus9.bcd);
    ovf_out = use8 ? bus8.overflow : bus9.overflow;
    check_eq("busy_low_at_done", use8 ? bus8.busy : bus9.busy, 0);
    $display("conv dut=%s bin=%0d bcd=0x%0h ovf=%0d lat=%0d",
             use8 ? "n8d2" : "n9d3", v, bcd_out, ovf_out, lat);
    @(negedge clock);
    check_eq("done_one_cycle", use8 ? bus8.done : bus9.done, 0);
  endtask

  int          lat;
  int          lat2;
  int unsigned bcd_v;
  bit          ovf_v;
  bit          seen_done;

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus9.start = 1'b0;
    bus9.bin   = '0;
    bus8.start = 1'b0;
    bus8.bin   = '0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clock);
    check_eq("rst_busy", bus9.busy, 0);
    check_eq("rst_done", bus9.done, 0);
    check_eq("rst_bcd", bus9.bcd, 0);
    check_eq("rst_ovf", bus9.overflow, 0);
    resetn = 1'b1;

    // ---------------- directed N=9 DIGITS=3 ----------------
    run_conv(1'b0, 0, lat, bcd_v, ovf_v);
    check_eq("lat_0", lat, 9);
    check_eq("bcd_0", bcd_v, 32'h000);
    check_eq("ovf_0", ovf_v, 0);

    run_conv(1'b0, 511, lat, bcd_v, ovf_v);
    check_eq("lat_511", lat, 9);
    check_eq("bcd_511", bcd_v, 32'h511);
    check_eq("ovf_511", ovf_v, 0);

    run_conv(1'b0, 255, lat, bcd_v, ovf_v);
    check_eq("lat_255", lat, 9);
    check_eq("bcd_255", bcd_v, 32'h255);

    run_conv(1'b0, 100, lat, bcd_v, ovf_v);
    check_eq("lat_100", lat, 9);
    check_eq("bcd_100", bcd_v, 32'h100);
    check_eq("bcd_held", bus9.bcd, 32'h100);

    // ---------------- start held high ----------------
    @(negedge clock);
    bus9.start = 1'b1;
    bus9.bin   = 9'd37;
    @(negedge clock);
    bus9.bin = 9'd480;
    lat = 0;
    while (!bus9.done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check_eq("held_lat1", lat, 9);
    check_eq("held_bcd1", bus9.bcd, 32'h037);
    $display("conv dut=n9d3 bin=37 bcd=0x%0h ovf=%0d lat=%0d", bus9.bcd, bus9.overflow, lat);
    @(negedge clock);
    check_eq("held_rebusy", bus9.busy, 1);
    check_eq("held_done_low", bus9.done, 0);
    check_eq("held_bcd_stable", bus9.bcd, 32'h037);
    lat2 = 1;
    while (!bus9.done && lat2 < 40) begin
      @(negedge clock);
      lat2++;
    end
    bus9.start = 1'b0;
    check_eq("held_spacing", lat2, 10);
    check_eq("held_bcd2", bus9.bcd, 32'h480);
    $display("conv dut=n9d3 bin=480 bcd=0x%0h ovf=%0d spacing=%0d", bus9.bcd, bus9.overflow, lat2);
    @(negedge clock);
    check_eq("held_no_third", bus9.busy, 0);

    // ---------------- N=8 DIGITS=2 ----------------
    run_conv(1'b1, 99, lat, bcd_v, ovf_v);
    check_eq("n8_lat_99", lat, 8);
    check_eq("n8_bcd_99", bcd_v, 32'h99);
    check_eq("n8_ovf_99", ovf_v, 0);

    run_conv(1'b1, 200, lat, bcd_v, ovf_v);
    check_eq("n8_lat_200", lat, 8);
    check_eq("n8_ovf_200", ovf_v, 1);

    // ---------------- reset mid-conversion ----------------
    @(negedge clock);
    bus9.start = 1'b1;
    bus9.bin   = 9'd300;
    @(negedge clock);
    bus9.start = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_busy", bus9.busy, 0);
    check_eq("mid_rst_done", bus9.done, 0);
    check_eq("mid_rst_bcd", bus9.bcd, 0);
    check_eq("mid_rst_ovf8", bus8.overflow, 0);
    @(negedge clock);
    resetn = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (bus9.done) seen_done = 1'b1;
    end
    check_eq("mid_rst_no_done", seen_done, 0);

    run_conv(1'b0, 42, lat, bcd_v, ovf_v);
    check_eq("post_rst_lat", lat, 9);
    check_eq("post_rst_bcd", bcd_v, 32'h042);

    // ---------------- exhaustive sweep N=9 ----------------
    for (int v = 0; v < 512; v++) begin
      run_conv(1'b0, v, lat, bcd_v, ovf_v);
      check_eq("sweep_lat", lat, 9);
      check_eq("sweep_bcd", bcd_v, ref_bcd3(v));
      check_eq("sweep_ovf", ovf_v, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_binary_to_bcd_serial
